// File: rtl/capture_rle_encoder.sv
// Run-length encoder for the logic-analyser capture path: folds equal samples into
// {run_cnt, sample} words and hands them to the CDC FIFO through a one-entry register.
module capture_rle_encoder #(
    parameter int CHANNELS = 24
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                rle_en_i,
    input  logic                sample_valid_i,
    input  logic [CHANNELS-1:0] sample_i,
    input  logic                accept_i,
    output logic [31:0]         data_o,
    output logic                valid_o,
    output logic                overflow_o,
    output logic                busy_o
);

    localparam int CNT_W = 32 - CHANNELS;

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH} state_t;

    // Handshake: a word is delivered in any cycle where valid_o && accept_i;
    // valid_o never waits on accept_i, and data_o is stable while valid_o holds.
    state_t              state_q, state_d;
    logic                enable_q;
    logic                run_valid_q, run_valid_d;
    logic [CHANNELS-1:0] cur_q, cur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                overflow_q, overflow_d;
    logic                start;
    logic                free;
    logic                emit;

    assign start = enable_i && !enable_q;
    // Back-to-back: a held word retiring this cycle frees the slot for a new one.
    assign free  = !valid_q || accept_i;

    always_comb begin
        state_d     = state_q;
        run_valid_d = run_valid_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        overflow_d  = overflow_q;
        emit        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CAPTURE;
                    overflow_d  = 1'b0;
                    run_valid_d = 1'b0;
                    if (sample_valid_i) begin
                        cur_d       = sample_i;
                        cnt_d       = '0;
                        run_valid_d = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (!enable_i) begin
                    state_d = run_valid_q ? FLUSH : IDLE;
                end else if (sample_valid_i) begin
                    if (!run_valid_q) begin
                        cur_d       = sample_i;
                        cnt_d       = '0;
                        run_valid_d = 1'b1;
                    end else if (rle_en_i && (sample_i == cur_q) && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        emit  = 1'b1;
                        cur_d = sample_i;
                        cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (free) begin
                    emit        = 1'b1;
                    run_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && accept_i) begin
            valid_d = 1'b0;
        end
        // A word that finds the register occupied is lost; sampling keeps going.
        if (emit) begin
            if (free) begin
                data_d  = {cnt_q, cur_q};
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            enable_q    <= 1'b0;
            run_valid_q <= 1'b0;
            cur_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_i;
            run_valid_q <= run_valid_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_capture_rle_encoder.sv
// Directed bench for capture_rle_encoder: timed checks on the output register plus
// a record of every delivered word compared against hand-computed word lists.
module tb_capture_rle_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        rle_en;
    logic        sample_valid;
    logic [23:0] sample;
    logic        accept;
    logic [31:0] data;
    logic        valid;
    logic        overflow;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] del_q[$];

    localparam logic [23:0] A = 24'h00000F;
    localparam logic [23:0] B = 24'h0000F0;
    localparam logic [23:0] C = 24'h000C00;

    capture_rle_encoder #(.CHANNELS(24)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .rle_en_i       (rle_en),
        .sample_valid_i (sample_valid),
        .sample_i       (sample),
        .accept_i       (accept),
        .data_o         (data),
        .valid_o        (valid),
        .overflow_o     (overflow),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so at negedge they show the coming handshake.
    always @(negedge clk) begin
        if (rst_n && valid && accept) del_q.push_back(data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_word();
        if (del_q.size() == 0) return 32'hDEAD_BEEF;
        return del_q.pop_front();
    endfunction

    initial begin
        rst_n = 1'b0; enable = 1'b0; rle_en = 1'b1; sample_valid = 1'b0;
        sample = '0; accept = 1'b1;
        #2;
        check("rst_data", data, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Reset mid-stream with a word held
        accept = 1'b0; enable = 1'b1; sample_valid = 1'b1; sample = A;
        step();
        sample = B;
        step();
        check("pre_rst_valid", 32'(valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", data, 32'h0);
        check("async_rst_valid", 32'(valid), 32'h0);
        check("async_rst_ovf", 32'(overflow), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        enable = 1'b0; sample_valid = 1'b0; accept = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_word", 32'(valid), 32'h0);
        end
        del_q.delete();

        // Basic run: A x3 then B, then disable
        enable = 1'b1; sample_valid = 1'b1; sample = A;
        repeat (3) step();
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_no_word_yet", 32'(valid), 32'h0);
        sample = B;
        step();
        check("basic_word1_valid", 32'(valid), 32'h1);
        check("basic_word1", data, 32'h0200_000F);
        enable = 1'b0; sample_valid = 1'b0;
        step();
        check("basic_flush_busy", 32'(busy), 32'h1);
        check("basic_retired", 32'(valid), 32'h0);
        step();
        check("basic_flush_valid", 32'(valid), 32'h1);
        check("basic_flush_word", data, 32'h0000_00F0);
        check("basic_idle", 32'(busy), 32'h0);
        step();
        check("basic_count", 32'(del_q.size()), 32'd2);
        del_q.delete();

        // Saturation: 300 equal samples -> 256 + 44
        enable = 1'b1; sample_valid = 1'b1; sample = A;
        repeat (300) step();
        enable = 1'b0; sample_valid = 1'b0;
        repeat (4) step();
        check("sat_count", 32'(del_q.size()), 32'd2);
        check("sat_word_full", pop_word(), 32'hFF00_000F);
        check("sat_word_rest", pop_word(), 32'h2B00_000F);
        check("sat_ovf", 32'(overflow), 32'h0);
        del_q.delete();

        // Backpressure: A, B, C with accept low
        accept = 1'b0; enable = 1'b1; sample_valid = 1'b1; sample = A;
        step();
        sample = B;
        step();
        sample = C;
        step();
        check("bp_valid", 32'(valid), 32'h1);
        check("bp_held", data, 32'h0000_000F);
        check("bp_ovf", 32'(overflow), 32'h1);
        accept = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        repeat (4) step();
        check("bp_count", 32'(del_q.size()), 32'd2);
        check("bp_word_a", pop_word(), 32'h0000_000F);
        check("bp_word_c", pop_word(), 32'h0000_0C00);
        check("bp_ovf_sticky", 32'(overflow), 32'h1);
        del_q.delete();

        // RLE off: three A samples -> three words
        rle_en = 1'b0; enable = 1'b1; sample_valid = 1'b1; sample = A;
        step();
        check("ovf_cleared_on_start", 32'(overflow), 32'h0);
        repeat (2) step();
        enable = 1'b0; sample_valid = 1'b0;
        repeat (4) step();
        check("norle_count", 32'(del_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("norle_word", pop_word(), 32'h0000_000F);
        del_q.delete();

        // Back-to-back: alternating A/B every cycle
        rle_en = 1'b1; enable = 1'b1; sample_valid = 1'b1; sample = A;
        step();
        for (int k = 2; k <= 8; k++) begin
            sample = (k % 2 == 0) ? B : A;
            step();
            check("b2b_valid", 32'(valid), 32'h1);
            check("b2b_data", data, (k % 2 == 0) ? {8'h00, A} : {8'h00, B});
        end
        enable = 1'b0; sample_valid = 1'b0;
        repeat (4) step();
        check("b2b_count", 32'(del_q.size()), 32'd8);
        check("b2b_ovf", 32'(overflow), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
